// File: rtl/elastic_buffer.sv
// rtl/elastic_buffer.sv - valid/ready elastic buffer with flush, occupancy and optional fall-through
module elastic_buffer #(
    parameter int DLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int OUT_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DLEN-1:0]              i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DLEN-1:0]              o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_afull
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic empty;
    logic use_bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    // o_ready looks only at registered state, so the downstream ready never
    // reaches upstream combinationally.
    always_comb begin
        empty      = (count_q == '0);
        use_bypass = (OUT_REG == 0) && empty;
        o_ready    = rstn & ~i_flush & (count_q < CW'(DEPTH));

        if (use_bypass) begin
            o_valid = i_valid & rstn & ~i_flush;
        end else begin
            o_valid = ~empty & rstn & ~i_flush;
        end

        o_data = '0;
        if (o_valid) begin
            o_data = use_bypass ? i_data : mem_q[rd_ptr_q];
        end

        push = i_valid & o_ready;
        pop  = o_valid & i_ready;

        // A bypassed beat that is consumed immediately never touches storage.
        wr_en = push & ~(use_bypass & pop);
        rd_en = pop & ~use_bypass;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_count = rstn ? count_q : '0;
    assign o_afull = rstn & (count_q >= CW'(AFULL_LVL));

endmodule

// File: tb/tb_elastic_buffer.sv
// tb/tb_elastic_buffer.sv - random and directed checks of elastic_buffer in both output modes
module tb_elastic_buffer;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int SLEN  = 4096;

    logic        clk = 1'b0;
    logic        rstn, flush, valid, ready;
    logic [31:0] data;

    logic [1:0]  ob_ready, ob_valid, ob_afull;
    logic [31:0] ob_data  [2];
    logic [2:0]  ob_count [2];

    int n_cmp = 0;
    int n_err = 0;

    // Reference: every accepted beat gets a sequence number; occupancy is wr_n - rd_n.
    logic [31:0] stream [2][SLEN];
    int          wr_n [2];
    int          rd_n [2];

    always #5 clk = ~clk;

    elastic_buffer #(.DLEN(32), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .OUT_REG(0)) dut_f (
        .clk(clk), .rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(ob_ready[0]),
        .i_data(data), .o_valid(ob_valid[0]), .i_ready(ready), .o_data(ob_data[0]),
        .o_count(ob_count[0]), .o_afull(ob_afull[0])
    );

    elastic_buffer #(.DLEN(32), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .OUT_REG(1)) dut_r (
        .clk(clk), .rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(ob_ready[1]),
        .i_data(data), .o_valid(ob_valid[1]), .i_ready(ready), .o_data(ob_data[1]),
        .o_count(ob_count[1]), .o_afull(ob_afull[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [31:0] d, input logic rd);
        bit do_pop [2];
        bit do_push [2];
        bit byp [2];
        rstn  = r;
        flush = f;
        valid = v;
        data  = d;
        ready = rd;
        #1;
        for (int m = 0; m < 2; m++) begin
            int          sz = wr_n[m] - rd_n[m];
            bit          er = r && !f && (sz < DEPTH);
            bit          ev;
            logic [31:0] ed;
            if (m == 1 || sz > 0) begin
                ev = r && !f && (sz > 0);
                ed = ev ? stream[m][rd_n[m] % SLEN] : 32'h0;
            end else begin
                ev = r && !f && v;
                ed = ev ? d : 32'h0;
            end
            check($sformatf("m%0d o_ready", m), 32'(ob_ready[m]), 32'(er));
            check($sformatf("m%0d o_valid", m), 32'(ob_valid[m]), 32'(ev));
            check($sformatf("m%0d o_data", m),  ob_data[m], ed);
            check($sformatf("m%0d o_count", m), 32'(ob_count[m]), r ? 32'(sz) : 32'h0);
            check($sformatf("m%0d o_afull", m), 32'(ob_afull[m]), 32'(r && sz >= AFULL));
            do_pop[m]  = ev && rd;
            do_push[m] = v && er;
            byp[m]     = (m == 0) && (sz == 0) && do_pop[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!r || f) begin
                rd_n[m] = wr_n[m];
            end else if (!byp[m]) begin
                if (do_pop[m])  rd_n[m]++;
                if (do_push[m]) begin
                    stream[m][wr_n[m] % SLEN] = d;
                    wr_n[m]++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        wr_n = '{0, 0};
        rd_n = '{0, 0};
        rstn = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
        @(negedge clk);
        repeat (3) cycle(0, 0, 0, 32'h0, 0);

        // Fill with downstream stalled, then drain in order.
        cycle(1, 0, 1, 32'hA, 0);
        cycle(1, 0, 1, 32'hB, 0);
        cycle(1, 0, 1, 32'hC, 0);
        cycle(1, 0, 1, 32'hD, 0);
        #1;
        check("full count", 32'(ob_count[1]), 32'd4);
        check("full ready", 32'(ob_ready[1]), 32'd0);
        check("full head",  ob_data[1], 32'hA);
        // Full with push attempt and pop: only the pop completes.
        cycle(1, 0, 1, 32'hE, 1);
        #1;
        check("after pop count", 32'(ob_count[1]), 32'd3);
        cycle(1, 0, 1, 32'hF, 0);
        repeat (5) cycle(1, 0, 0, 32'h0, 1);

        // Fall-through: consumed in the same cycle, count stays zero.
        rstn = 1; flush = 0; valid = 1; data = 32'hDEADBEEF; ready = 1;
        #1;
        check("bypass valid", 32'(ob_valid[0]), 32'd1);
        check("bypass data",  ob_data[0], 32'hDEADBEEF);
        check("bypass count", 32'(ob_count[0]), 32'd0);
        cycle(1, 0, 1, 32'hDEADBEEF, 1);
        cycle(1, 0, 1, 32'hDEADBEEF, 0);
        cycle(1, 0, 0, 32'h0, 0);
        check("stored hold", ob_data[0], 32'hDEADBEEF);
        cycle(1, 0, 0, 32'h0, 1);

        // Full-rate streaming across pointer wrap.
        for (int i = 0; i < 16; i++) cycle(1, 0, 1, 32'h100 + 32'(i), 1);
        repeat (3) cycle(1, 0, 0, 32'h0, 1);

        // Flush at count 3 with both handshakes offered.
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 32'h200 + 32'(i), 0);
        cycle(1, 1, 1, 32'h2FF, 1);
        cycle(1, 0, 0, 32'h0, 0);
        check("post flush count", 32'(ob_count[1]), 32'd0);

        // Reset mid-stream at count 2.
        cycle(1, 0, 1, 32'h300, 0);
        cycle(1, 0, 1, 32'h301, 0);
        cycle(0, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 1);
        check("post reset ready", 32'(ob_ready[1]), 32'd1);

        // Random traffic with phases of varying pressure.
        for (int i = 0; i < 1500; i++) begin
            int vp = (i / 250) % 2 ? 85 : 50;
            int rp = (i / 250) % 3 == 0 ? 30 : 75;
            cycle(($urandom_range(99) >= 2) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < vp) ? 1'b1 : 1'b0,
                  $urandom,
                  ($urandom_range(99) < rp) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
